vernier_step_gen: RTL and testbench

Sequential generator that drives the vernier phase-step index for the StreamETS equivalent-time sampling path. It sweeps the step index from T_MIN to T_MAX, capturing a programmable number of averages per step, and issues each step through a valid/ready handshake. It waits for the capture engine to report completion before advancing. The emitted index feeds the step-to-time point map downstream; the block also outputs the nominal point time, computed by accumulation.

---
 rtl/vernier_step_gen_if.sv | 26 ++
 rtl/vernier_step_gen.sv | 160 ++++++++++++++++
 tb/tb_vernier_step_gen.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vernier_step_gen_if.sv
// Step-issue bus for vernier_step_gen: sweep control, step handshake and capture status.
// The master side is the generator; the slave side is the sequencer/capture engine.
interface vernier_step_gen_if;
  logic        start;
  logic        stop;
  logic        cont;
  logic [7:0]  num_avg;
  logic [7:0]  step_t;
  logic [15:0] point_time;
  logic        step_valid;
  logic        step_ready;
  logic        capture_done;
  logic        busy;
  logic        sweep_done;
  logic        timeout_err;

  modport master (
    input  start, stop, cont, num_avg, step_ready, capture_done,
    output step_t, point_time, step_valid, busy, sweep_done, timeout_err
  );

  modport slave (
    output start, stop, cont, num_avg, step_ready, capture_done,
    input  step_t, point_time, step_valid, busy, sweep_done, timeout_err
  );
endinterface

// File: rtl/vernier_step_gen.sv
// Vernier phase-step sweep generator: issues T_MIN..T_MAX (num_avg times each) with an accumulated point time.
// Optional capture watchdog enabled by defining VERNIER_TIMEOUT_EN.
module vernier_step_gen #(
  parameter int unsigned T_MIN     = 2,
  parameter int unsigned T_MAX     = 120,
  parameter int unsigned STEP_PS   = 88,
  parameter int unsigned OFFSET_PS = 11,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  vernier_step_gen_if.master bus
);

  localparam logic [15:0] PT_INIT = 16'(STEP_PS * T_MIN + OFFSET_PS);
  localparam logic [15:0] PT_STEP = 16'(STEP_PS);
  localparam logic [6:0]  T_FIRST = 7'(T_MIN);
  localparam logic [6:0]  T_LAST  = 7'(T_MAX);

  if (T_MIN > T_MAX || T_MAX > 127 || TIMEOUT < 1) begin : g_param_check
    $error("vernier_step_gen: invalid parameter set");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

  state_t      state_q;
  logic [6:0]  t_q;
  logic        par_q;
  logic [15:0] pt_q;
  logic [7:0]  avg_q;
  logic [7:0]  avg_d;
  logic [7:0]  navg_q;
  logic        valid_q;
  logic        busy_q;
  logic        sdone_q;

  assign avg_d = avg_q + 8'd1;

`ifdef VERNIER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;
  logic            terr_q;

  assign wd_d = wd_q + WD_W'(1);
  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      par_q   <= 1'b0;
      pt_q    <= '0;
      avg_q   <= '0;
      navg_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      sdone_q <= 1'b0;
`ifdef VERNIER_TIMEOUT_EN
      wd_q    <= '0;
      terr_q  <= 1'b0;
`endif
    end else begin
      sdone_q <= 1'b0;
      // stop overrides everything, including a simultaneous start; position and parity hold
      if (bus.stop) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start) begin
              navg_q  <= (bus.num_avg == 8'd0) ? 8'd1 : bus.num_avg;
              t_q     <= T_FIRST;
              pt_q    <= PT_INIT;
              avg_q   <= '0;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ISSUE;
`ifdef VERNIER_TIMEOUT_EN
              terr_q  <= 1'b0;
`endif
            end
          end
          ISSUE: begin
            if (bus.step_ready) begin
              valid_q <= 1'b0;
              state_q <= WAIT;
`ifdef VERNIER_TIMEOUT_EN
              wd_q    <= '0;
`endif
            end
          end
          WAIT: begin
`ifdef VERNIER_TIMEOUT_EN
            if (bus.capture_done) begin
              state_q <= NEXT;
            end else if (wd_d == WD_W'(TIMEOUT)) begin
              terr_q  <= 1'b1;
              state_q <= NEXT;
            end else begin
              wd_q <= wd_d;
            end
`else
            if (bus.capture_done) begin
              state_q <= NEXT;
            end
`endif
          end
          NEXT: begin
            if (avg_d < navg_q) begin
              avg_q   <= avg_d;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end else if (t_q == T_LAST) begin
              sdone_q <= 1'b1;
              par_q   <= ~par_q;
              state_q <= DONE;
            end else begin
              t_q     <= t_q + 7'd1;
              pt_q    <= pt_q + PT_STEP;
              avg_q   <= '0;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
          DONE: begin
            // continuous mode reuses the num_avg latched at the original start
            if (bus.cont) begin
              t_q     <= T_FIRST;
              pt_q    <= PT_INIT;
              avg_q   <= '0;
              valid_q <= 1'b1;
              state_q <= ISSUE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.step_t     = {par_q, t_q};
  assign bus.point_time = pt_q;
  assign bus.step_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sdone_q;

endmodule

// File: tb/tb_vernier_step_gen.sv
// Scoreboard bench for vernier_step_gen: random ready/capture timing against a list-based sweep model.
`timescale 1ns/1ps
module tb_vernier_step_gen;
  localparam int T_MIN     = 2;
  localparam int T_MAX     = 120;
  localparam int STEP_PS   = 88;
  localparam int OFFSET_PS = 11;
  localparam int TIMEOUT   = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vernier_step_gen_if bus();

  vernier_step_gen #(
    .T_MIN(T_MIN), .T_MAX(T_MAX), .STEP_PS(STEP_PS), .OFFSET_PS(OFFSET_PS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int t;
    int par;
    int pt;
  } item_t;

  item_t exp_q[$];
  int    sd_q[$];
  int    parity_m = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // monitor-owned counters; main process only reads them
  int hs_cnt = 0;
  int sd_cnt = 0;
  int hs50_cnt = 0;
  int withhold_used = 0;
  int force_used = 0;
  // main-owned requests
  int withhold_req = 0;
  int force_req = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // expected handshakes of one sweep: every T in range, n consecutive copies each
  task automatic push_sweep(input int navg);
    int n;
    item_t it;
    n = (navg == 0) ? 1 : navg;
    for (int t = T_MIN; t <= T_MAX; t++) begin
      for (int k = 0; k < n; k++) begin
        it.t = t;
        it.par = parity_m;
        it.pt = STEP_PS * t + OFFSET_PS;
        exp_q.push_back(it);
      end
    end
    parity_m ^= 1;
    sd_q.push_back(parity_m);
  endtask

  // ---------------- monitor / consumer ----------------
  int          cd_cnt = 0;
  int          hold_cnt = 0;
  bit          prev_stall = 0;
  bit          prev_sd = 0;
  bit          prev_sd_cont = 0;
  logic [7:0]  prev_t;
  logic [15:0] prev_pt;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.step_ready = 1'b0;
      bus.capture_done = 1'b0;
      cd_cnt = 0;
      hold_cnt = 0;
      prev_stall = 0;
      prev_sd = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", int'(bus.step_valid), 1);
        check("stall_step_t_stable", int'(bus.step_t), int'(prev_t));
        check("stall_point_time_stable", int'(bus.point_time), int'(prev_pt));
      end
      if (prev_sd) begin
        if (prev_sd_cont) begin
          check("cont_restart_valid", int'(bus.step_valid), 1);
          check("cont_restart_t", int'(bus.step_t[6:0]), T_MIN);
        end else begin
          check("done_to_idle_busy", int'(bus.busy), 0);
        end
      end
      prev_sd = 0;
      if (bus.sweep_done) begin
        sd_cnt++;
        if (sd_q.size() == 0) check("unexpected_sweep_done", 1, 0);
        else check("sweep_done_parity", int'(bus.step_t[7]), sd_q.pop_front());
        prev_sd = 1;
        prev_sd_cont = bus.cont;
      end

      bus.capture_done = 1'b0;
      if (cd_cnt > 0) begin
        cd_cnt--;
        if (cd_cnt == 0) bus.capture_done = 1'b1;
      end
      if (force_req > force_used) begin
        force_used++;
        bus.capture_done = 1'b1;
      end

      if (bus.step_valid && bus.step_t[6:0] == 7'd10 && hold_cnt < 5) begin
        bus.step_ready = 1'b0;
        hold_cnt++;
      end else begin
        bus.step_ready = ($urandom_range(0, 3) != 0);
      end

      // a capture_done while a step is still being offered must be ignored
      if (bus.step_valid && !bus.step_ready && !bus.capture_done && cd_cnt == 0 &&
          $urandom_range(0, 3) == 0)
        bus.capture_done = 1'b1;

      if (bus.step_valid && bus.step_ready && !bus.stop) begin
        hs_cnt++;
        hold_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          check("hs_step_index", int'(bus.step_t[6:0]), it.t);
          check("hs_parity", int'(bus.step_t[7]), it.par);
          check("hs_point_time", int'(bus.point_time), it.pt);
        end
        if (bus.step_t[6:0] == 7'd50) hs50_cnt++;
        if (withhold_req > withhold_used) withhold_used++;
        else cd_cnt = $urandom_range(1, 3);
      end

      prev_stall = bus.step_valid && !bus.step_ready && !bus.stop;
      prev_t = bus.step_t;
      prev_pt = bus.point_time;
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int navg);
    bus.num_avg = 8'(navg);
    bus.start = 1'b1;
    @(negedge clk);
    check("start_to_valid", int'(bus.step_valid), 1);
    check("start_busy", int'(bus.busy), 1);
    #1;
    bus.start = 1'b0;
    bus.num_avg = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while (bus.busy === 1'b1 && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (i >= budget) check("wait_idle_budget_expired", 0, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic run_sweep(input int navg, input int exp_hs, input string tag);
    int hs0, sd0;
    hs0 = hs_cnt;
    sd0 = sd_cnt;
    push_sweep(navg);
    pulse_start(navg);
    wait_idle(9000);
    check({tag, "_handshakes"}, hs_cnt - hs0, exp_hs);
    check({tag, "_sweep_done_count"}, sd_cnt - sd0, 1);
    check({tag, "_end_parity"}, int'(bus.step_t[7]), parity_m);
    check({tag, "_end_busy"}, int'(bus.busy), 0);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int hs0, sd0, i, h50;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.cont = 1'b0;
    bus.num_avg = 8'd1;
    repeat (3) @(negedge clk);
    check("reset_step_t", int'(bus.step_t), 0);
    check("reset_point_time", int'(bus.point_time), 0);
    check("reset_step_valid", int'(bus.step_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_sweep_done", int'(bus.sweep_done), 0);
    check("reset_timeout_err", int'(bus.timeout_err), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    run_sweep(1, 119, "basic");
    run_sweep(3, 357, "avg3");
    run_sweep(0, 119, "avg0");

    // abort in WAIT at T=50
    push_sweep(1);
    h50 = hs50_cnt;
    pulse_start(1);
    i = 0;
    while (hs50_cnt == h50 && i < 3000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (i >= 3000) check("abort_reach_t50_budget", 0, 1);
    @(negedge clk);
    #1 bus.stop = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_valid", int'(bus.step_valid), 0);
    check("abort_sweep_done", int'(bus.sweep_done), 0);
    check("abort_t_held", int'(bus.step_t[6:0]), 50);
    check("abort_point_time_held", int'(bus.point_time), STEP_PS * 50 + OFFSET_PS);
    #1 bus.stop = 1'b0;
    exp_q.delete();
    sd_q.delete();
    parity_m ^= 1;
    check("abort_parity_held", int'(bus.step_t[7]), parity_m);
    repeat (6) @(negedge clk);
    #1;
    check("abort_still_idle", int'(bus.busy), 0);
    run_sweep(1, 119, "restart");

    // continuous mode: three back-to-back sweeps
    hs0 = hs_cnt;
    sd0 = sd_cnt;
    repeat (3) push_sweep(1);
    bus.cont = 1'b1;
    pulse_start(1);
    i = 0;
    while (sd_cnt - sd0 < 2 && i < 9000) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (i >= 9000) check("cont_two_sweeps_budget", 0, 1);
    repeat (3) @(negedge clk);
    #1 bus.cont = 1'b0;
    wait_idle(9000);
    check("cont_handshakes", hs_cnt - hs0, 357);
    check("cont_sweep_done_count", sd_cnt - sd0, 3);
    check("cont_queue_drained", exp_q.size(), 0);

    // capture watchdog: withhold the first capture_done
    hs0 = hs_cnt;
    push_sweep(1);
    withhold_req++;
    pulse_start(1);
`ifdef VERNIER_TIMEOUT_EN
    i = 0;
    while (bus.timeout_err !== 1'b1 && i < 1200) begin
      @(negedge clk);
      #1;
      i++;
    end
    check("wd_timeout_err_set", int'(bus.timeout_err), 1);
    check("wd_latency_window", int'(i >= TIMEOUT - 8 && i <= TIMEOUT + 8), 1);
    wait_idle(9000);
    check("wd_handshakes", hs_cnt - hs0, 119);
    check("wd_err_sticky", int'(bus.timeout_err), 1);
`else
    repeat (1100) @(negedge clk);
    #1;
    check("nowd_busy_in_wait", int'(bus.busy), 1);
    check("nowd_valid_low", int'(bus.step_valid), 0);
    check("nowd_timeout_err", int'(bus.timeout_err), 0);
    check("nowd_t_unchanged", int'(bus.step_t[6:0]), T_MIN);
    force_req++;
    wait_idle(9000);
    check("nowd_handshakes", hs_cnt - hs0, 119);
`endif

    // asynchronous reset mid-sweep
    push_sweep(1);
    pulse_start(1);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(bus.step_valid), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_step_t", int'(bus.step_t), 0);
    check("arst_point_time", int'(bus.point_time), 0);
    exp_q.delete();
    sd_q.delete();
    parity_m = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_resume", int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
